// File: rtl/siso_johnson8.sv
// rtl/siso_johnson8.sv - serial delay line stored in a circular bit array addressed by Johnson phase
module siso_johnson8 #(
  parameter int JW = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              D_IN,
  output logic              D_OUT,
  output logic [JW-1:0]     JOHNSON,
  output logic [2*JW-1:0]   PULSES,
  output logic              WRAP
);

  localparam int DEPTH = 2 * JW;

  logic [JW-1:0]    johnson_q, johnson_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             d_out_q, d_out_d;
  logic [DEPTH-1:0] pulses;
  logic             legal;

  // Legal Johnson code for phase k: k low ones while filling, then ones drain from the bottom.
  function automatic logic [JW-1:0] phase_pattern(input int k);
    logic [JW-1:0] p;
    p = '0;
    for (int b = 0; b < JW; b++) begin
      if (k <= JW) p[b] = (b < k);
      else         p[b] = (b >= k - JW);
    end
    return phase_pattern_ret(p);
  endfunction

  function automatic logic [JW-1:0] phase_pattern_ret(input logic [JW-1:0] p);
    return p;
  endfunction

  // One-hot phase decode; an illegal state matches no phase and yields all zeros.
  always_comb begin
    pulses = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (johnson_q == phase_pattern(k)) pulses[k] = 1'b1;
    end
    legal = |pulses;
  end

  // Next state: read the current cell before overwriting it, so latency is exactly DEPTH edges.
  always_comb begin
    johnson_d = legal ? {johnson_q[JW-2:0], ~johnson_q[JW-1]} : '0;
    d_out_d   = |(mem_q & pulses);
    mem_d     = (mem_q & ~pulses) | (pulses & {DEPTH{D_IN}});
  end

  // State registers; EN low freezes everything.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      johnson_q <= '0;
      mem_q     <= '0;
      d_out_q   <= 1'b0;
    end else if (EN) begin
      johnson_q <= johnson_d;
      mem_q     <= mem_d;
      d_out_q   <= d_out_d;
    end
  end

  assign D_OUT   = d_out_q;
  assign JOHNSON = johnson_q;
  assign PULSES  = pulses;
  assign WRAP    = pulses[DEPTH-1];

endmodule

// File: tb/tb_siso_johnson8.sv
// tb/tb_siso_johnson8.sv - directed self-checking bench for siso_johnson8
module tb_siso_johnson8;

  logic       CLK;
  logic       RESET;
  logic       EN;
  logic       D_IN;
  logic       D_OUT;
  logic [3:0] JOHNSON;
  logic [7:0] PULSES;
  logic       WRAP;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] jseq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int         ph;
  logic [7:0] hist;
  logic       exp_q;
  logic [7:0] pat;
  logic [7:0] out_byte;

  siso_johnson8 #(.JW(4)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .D_IN    (D_IN),
    .D_OUT   (D_OUT),
    .JOHNSON (JOHNSON),
    .PULSES  (PULSES),
    .WRAP    (WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_phase(input string tag);
    chk({tag, ".johnson"}, 32'(JOHNSON), 32'(jseq[ph]));
    chk({tag, ".pulses"},  32'(PULSES),  32'(8'(1) << ph));
    chk({tag, ".wrap"},    32'(WRAP),    32'(ph == 7));
  endtask

  task automatic en_step(input logic din);
    D_IN = din;
    EN   = 1'b1;
    step();
    ph    = (ph + 1) % 8;
    exp_q = hist[7];
    hist  = {hist[6:0], din};
  endtask

  task automatic sync_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    ph    = 0;
    hist  = '0;
    exp_q = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    EN    = 1'b0;
    D_IN  = 1'b0;
    ph    = 0;
    hist  = '0;
    exp_q = 1'b0;
    pat   = 8'hB5;

    // Asynchronous reset mid-cycle, checked before any clock edge
    #12;
    RESET = 1'b1;
    #1;
    chk("rst.d_out",   32'(D_OUT),   32'(1'b0));
    chk("rst.johnson", 32'(JOHNSON), 32'(4'b0000));
    chk("rst.pulses",  32'(PULSES),  32'(8'h01));
    chk("rst.wrap",    32'(WRAP),    32'(1'b0));
    @(negedge CLK);
    RESET = 1'b0;
    EN    = 1'b1;

    // Sequence: two full laps
    for (int i = 0; i < 16; i++) begin
      ph = i % 8;
      chk_phase("seq");
      step();
    end
    ph = 0;
    chk_phase("seq.end");

    // Latency of a single 1
    sync_reset();
    EN   = 1'b1;
    en_step(1'b1);
    for (int e = 1; e <= 10; e++) begin
      en_step(1'b0);
      chk("lat.d_out", 32'(D_OUT), 32'(e == 8));
    end

    // 0xB5 LSB-first with random disabled gaps
    out_byte = '0;
    for (int m = 0; m < 16; m++) begin
      int g;
      g  = int'($urandom_range(3, 1));
      EN = 1'b0;
      for (int j = 0; j < g; j++) begin
        D_IN = ~D_IN;
        step();
        chk_phase("gap");
        chk("gap.d_out", 32'(D_OUT), 32'(exp_q));
      end
      en_step(m < 8 ? pat[m] : 1'b0);
      chk("pat.d_out", 32'(D_OUT), 32'(exp_q));
      chk("pat.johnson", 32'(JOHNSON), 32'(jseq[ph]));
      if (m >= 8) out_byte[m-8] = D_OUT;
    end
    chk("pat.byte", 32'(out_byte), 32'(8'hB5));

    // Fill with ones, then illegal-state recovery
    for (int e = 0; e < 9; e++) en_step(1'b1);
    chk("fill.d_out", 32'(D_OUT), 32'(1'b1));
    EN = 1'b0;
    force dut.johnson_q = 4'b0101;
    #1;
    chk("ill.pulses", 32'(PULSES), 32'(8'h00));
    chk("ill.wrap",   32'(WRAP),   32'(1'b0));
    release dut.johnson_q;
    @(negedge CLK);
    D_IN = 1'b1;
    EN   = 1'b1;
    step();
    chk("ill.johnson", 32'(JOHNSON), 32'(4'b0000));
    chk("ill.d_out",   32'(D_OUT),   32'(1'b0));
    step();
    ph = 1;
    chk_phase("ill.resume");
    chk("ill.resume.d_out", 32'(D_OUT), 32'(1'b1));

    // Mid-stream reset discards the stored ones
    for (int e = 0; e < 8; e++) en_step(1'b1);
    #2;
    RESET = 1'b1;
    #1;
    chk("mrst.d_out",   32'(D_OUT),   32'(1'b0));
    chk("mrst.johnson", 32'(JOHNSON), 32'(4'b0000));
    @(negedge CLK);
    sync_reset();
    for (int e = 0; e < 10; e++) begin
      en_step(1'b0);
      chk("mrst.stream", 32'(D_OUT), 32'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/siso_johnson8.md
Name: siso_johnson8

Overview:
- Serial-in/serial-out delay stage. It consumes the resynchronised serial bit (from D_IN or the LFSR, mux-selected upstream) and returns it on D_OUT exactly DEPTH enabled clocks later.
- Storage is a circular bit array addressed by a Johnson-counter phase, not a physical shift chain. Only one cell is written per clock, which is the high-density goal.
- The Johnson state and its one-hot phase decode are exported for the top-level pins (Johnson[3:0], PULSES[7:0]).

Parameters:
- JW, 4, Johnson counter width. DEPTH = 2*JW phases/cells. Legal range 2..8.

Ports:
- CLK  input  1  stage clock (the selected CLK_OUT of the top level)
- RESET  input  1  asynchronous, active-high reset
- EN  input  1  shift enable; 0 = freeze all state
- D_IN  input  1  serial data in (SISO_in)
- D_OUT  output  1  registered serial data out
- JOHNSON  output  JW  current Johnson counter state
- PULSES  output  2*JW  one-hot phase decode of JOHNSON
- WRAP  output  1  high while in the last phase (index DEPTH-1)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While RESET=1:
  - JOHNSON=0, MEM[DEPTH-1:0]=0, D_OUT=0.
  - PULSES=one-hot bit 0 (8'b0000_0001 for JW=4), WRAP=0.
  - Deassertion takes effect at the next CLK edge.
- Johnson sequence: next = {J[JW-2:0], ~J[JW-1]}. For JW=4, phase indices 0..7 are 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Phase decode: PULSES[k]=1 only in legal state k. Combinational from JOHNSON, no glitch-free requirement.
- WRAP = PULSES[DEPTH-1].
- Illegal JOHNSON states (any value not in the legal sequence, e.g. 0101):
  - PULSES=0 and WRAP=0.
  - The next enabled edge loads 0000 (self-recovery).
  - No MEM write on that edge; D_OUT loads 0.
- Enabled edge (EN=1, RESET=0), all updates simultaneous, with k = current phase:
  - D_OUT <= MEM[k]
  - MEM[k] <= D_IN
  - JOHNSON advances one step.
- Read-before-write on the same cell: D_OUT gets the old MEM[k], never D_IN. Hence no bypass at DEPTH=...; latency is exact.
- Latency: a bit sampled on D_IN at enabled edge n appears on D_OUT after enabled edge n+DEPTH. It is valid for the whole following cycle and until the next enabled edge.
- EN=0: JOHNSON, MEM and D_OUT hold. PULSES and WRAP stay constant. Disabled cycles do not count toward latency.
- EN toggling every cycle is legal. Only enabled edges matter.
- Wrap-around: after phase DEPTH-1 the counter returns to phase 0 with no bubble. The stream is continuous across the wrap.
- Reset mid-operation: all stored bits are discarded (MEM=0). After release, D_OUT outputs DEPTH zeros before any new data.
- Single clock domain. No combinational path from D_IN to D_OUT.
- Resource target: JW + DEPTH + 1 flops. Write-enable decode from PULSES.

Test Plan:
- Reset check: assert RESET asynchronously mid-cycle. Outputs go immediately to D_OUT=0, JOHNSON=0000, PULSES=0x01, WRAP=0, without waiting for a CLK edge.
- Sequence check: release reset with EN=1 and run 16 clocks.
  - JOHNSON follows 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 twice.
  - PULSES follows 0x01, 0x02, 0x04, … 0x80 twice.
  - WRAP is high exactly on the 8th and 16th cycles.
- Latency: after reset, EN=1, drive D_IN=1 for one edge then 0. D_OUT=1 exactly on the cycle after the 8th subsequent enabled edge, for one cycle; 0 everywhere else.
- Pattern and gating: stream 0xB5 LSB-first while inserting EN=0 gaps of 1–3 cycles at random.
  - D_OUT reproduces 0xB5 after exactly 8 enabled edges.
  - All outputs are frozen during the gaps.
- Illegal-state recovery: force JOHNSON=0101 via the bench, then release.
  - Immediately: PULSES=0x00, WRAP=0.
  - After the next enabled edge: JOHNSON=0000 and D_OUT=0, and the normal sequence resumes.
- Mid-stream reset: fill the array with 1s (8 edges of D_IN=1), pulse RESET, then feed D_IN=0. D_OUT stays 0 for all subsequent edges.
